instr_cache: RTL and testbench

- Direct-mapped instruction cache that answers the CPU's instruction fetch: CPU presents PC, cache returns INSTRUCTION, or stalls the CPU via BUSYWAIT on a miss.
- Sits between the cpu fetch port and a slow 128-bit-line instruction memory.
- On a miss it refills a full 16-byte block from memory, then serves the fetch from the cache.

---
 rtl/instr_cache.sv | 132 +++++++++++++
 tb/tb_instr_cache.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with 16-byte blocks refilled from a 128-bit memory.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instr_cache #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_pc,
    output logic [31:0]           o_instruction,
    output logic                  o_busywait,
    output logic                  o_mem_read,
    output logic [ADDR_WIDTH-5:0] o_mem_address,
    input  logic [127:0]          i_mem_readdata,
    input  logic                  i_mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]           o_hit_count,
    output logic [15:0]           o_miss_count
`endif
);

    localparam int TAG_WIDTH  = ADDR_WIDTH - 4 - INDEX_WIDTH;
    localparam int NUM_BLOCKS = 1 << INDEX_WIDTH;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_READ = 2'd1;
    localparam logic [1:0] ST_UPDATE   = 2'd2;

    logic [1:0]             r_state;
    logic [ADDR_WIDTH-5:0]  r_mem_addr;
    logic [127:0]           r_refill;
    logic [NUM_BLOCKS-1:0]  r_valid;
    logic [TAG_WIDTH-1:0]   r_tag  [NUM_BLOCKS];
    logic [127:0]           r_data [NUM_BLOCKS];

    logic [1:0]             w_offset;
    logic [INDEX_WIDTH-1:0] w_index;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit;
    logic [127:0]           w_block;
    logic [31:0]            w_word;
    logic [INDEX_WIDTH-1:0] w_fill_index;
    logic [TAG_WIDTH-1:0]   w_fill_tag;
    logic                   w_unused_pc;

    assign w_offset     = i_pc[3:2];
    assign w_index      = i_pc[3+INDEX_WIDTH:4];
    assign w_tag        = i_pc[ADDR_WIDTH-1:4+INDEX_WIDTH];
    assign w_unused_pc  = ^{i_pc[31:ADDR_WIDTH], i_pc[1:0]};
    assign w_fill_index = r_mem_addr[INDEX_WIDTH-1:0];
    assign w_fill_tag   = r_mem_addr[ADDR_WIDTH-5:INDEX_WIDTH];

    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_block = r_data[w_index];

    always_comb begin
        w_word = w_block[31:0];
        case (w_offset)
            2'd0: w_word = w_block[31:0];
            2'd1: w_word = w_block[63:32];
            2'd2: w_word = w_block[95:64];
            2'd3: w_word = w_block[127:96];
            default: w_word = w_block[31:0];
        endcase
    end

    // Outputs are forced quiet while reset is held, even though the valid bits read as a miss.
    assign o_instruction = i_rst_n ? w_word : 32'd0;
    assign o_busywait    = i_rst_n && ((r_state != ST_IDLE) || !w_hit);
    assign o_mem_read    = (r_state == ST_MEM_READ);
    assign o_mem_address = r_mem_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_mem_addr <= '0;
            r_refill   <= '0;
            r_valid    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_hit) begin
                        r_state    <= ST_MEM_READ;
                        r_mem_addr <= {w_tag, w_index};
                    end
                end
                ST_MEM_READ: begin
                    if (!i_mem_busywait) begin
                        r_refill <= i_mem_readdata;
                        r_state  <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_valid[w_fill_index] <= 1'b1;
                    r_state               <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_UPDATE) begin
            r_data[w_fill_index] <= r_refill;
            r_tag[w_fill_index]  <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            end else begin
                if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache with a fixed-latency block memory model.
// Statistics counters are checked too when ICACHE_STATS_EN is defined.
module tb_instr_cache;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b1;
    logic [31:0]  i_pc = 32'd0;
    logic [31:0]  o_instruction;
    logic         o_busywait;
    logic         o_mem_read;
    logic [5:0]   o_mem_address;
    logic [127:0] i_mem_readdata;
    logic         i_mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  o_hit_count;
    logic [15:0]  o_miss_count;
`endif

    int checks = 0;
    int failures = 0;
    int memCnt = 0;

    localparam int MEM_LAT = 5;

    instr_cache dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pc           (i_pc),
        .o_instruction  (o_instruction),
        .o_busywait     (o_busywait),
        .o_mem_read     (o_mem_read),
        .o_mem_address  (o_mem_address),
        .i_mem_readdata (i_mem_readdata),
        .i_mem_busywait (i_mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .o_hit_count    (o_hit_count),
        .o_miss_count   (o_miss_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Memory block: base pattern 00,11,..,FF with every byte XORed by the block address.
    function automatic logic [127:0] blockData(input logic [5:0] blk);
        logic [127:0] d;
        for (int j = 0; j < 16; j++) begin
            d[j*8 +: 8] = (8'(j) * 8'h11) ^ {2'b00, blk};
        end
        return d;
    endfunction

    always @(posedge i_clk) memCnt <= o_mem_read ? memCnt + 1 : 0;

    assign i_mem_busywait = o_mem_read && (memCnt < MEM_LAT - 1);
    assign i_mem_readdata = blockData(o_mem_address);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc);
        stepCycle();
        i_pc = pc;
        #1;
    endtask

    task automatic waitReady(input string tag, input logic [5:0] expAddr);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < 40) begin
            if (o_mem_read) checkOutput({tag, "_addr"}, 32'(o_mem_address), 32'(expAddr));
            if (!o_busywait) done = 1'b1;
            else begin
                stepCycle();
                #1;
                n++;
            end
        end
        checkOutput({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(o_busywait), 32'd0);
        checkOutput("rst_instr", o_instruction, 32'd0);
        checkOutput("rst_memread", 32'(o_mem_read), 32'd0);
        checkOutput("rst_memaddr", 32'(o_mem_address), 32'd0);
`ifdef ICACHE_STATS_EN
        checkOutput("rst_hits", 32'(o_hit_count), 32'd0);
        checkOutput("rst_misses", 32'(o_miss_count), 32'd0);
`endif

        // First fetch after reset: 1 IDLE + 5 MEM_READ + 1 UPDATE busy cycles.
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        #1;
        checkOutput("c0_busy", 32'(o_busywait), 32'd1);
        checkOutput("c0_memread", 32'(o_mem_read), 32'd0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            #1;
            checkOutput("fill_memread", 32'(o_mem_read), 32'd1);
            checkOutput("fill_busy", 32'(o_busywait), 32'd1);
            checkOutput("fill_addr", 32'(o_mem_address), 32'h00);
        end
        stepCycle();
        #1;
        checkOutput("update_memread", 32'(o_mem_read), 32'd0);
        checkOutput("update_busy", 32'(o_busywait), 32'd1);
        stepCycle();
        #1;
        checkOutput("word0_busy", 32'(o_busywait), 32'd0);
        checkOutput("word0", o_instruction, 32'h33221100);

        applyStimulus(32'h004);
        checkOutput("word1", o_instruction, 32'h77665544);
        checkOutput("word1_busy", 32'(o_busywait), 32'd0);
        checkOutput("word1_memread", 32'(o_mem_read), 32'd0);
        applyStimulus(32'h008);
        checkOutput("word2", o_instruction, 32'hBBAA9988);
        checkOutput("word2_busy", 32'(o_busywait), 32'd0);
        applyStimulus(32'h00C);
        checkOutput("word3", o_instruction, 32'hFFEEDDCC);
        checkOutput("word3_busy", 32'(o_busywait), 32'd0);

        // Conflict on index 0 with tag 1 replaces the block.
        applyStimulus(32'h080);
`ifdef ICACHE_STATS_EN
        checkOutput("stat_hits", 32'(o_hit_count), 32'd4);
        checkOutput("stat_misses", 32'(o_miss_count), 32'd1);
`endif
        checkOutput("conflict_busy", 32'(o_busywait), 32'd1);
        waitReady("conflict", 6'h08);
        checkOutput("conflict_word0", o_instruction, 32'h3B2A1908);
        applyStimulus(32'h000);
        checkOutput("refetch0_busy", 32'(o_busywait), 32'd1);
        waitReady("refetch0", 6'h00);
        checkOutput("refetch0_word0", o_instruction, 32'h33221100);

        // PC moves while a refill is in flight; the latched address must hold.
        applyStimulus(32'h010);
        checkOutput("mid_busy", 32'(o_busywait), 32'd1);
        stepCycle();
        #1;
        checkOutput("mid_memread", 32'(o_mem_read), 32'd1);
        checkOutput("mid_addr0", 32'(o_mem_address), 32'h01);
        i_pc = 32'h020;
        #1;
        for (int n = 0; n < 20 && o_mem_read; n++) begin
            checkOutput("mid_addr_hold", 32'(o_mem_address), 32'h01);
            stepCycle();
            #1;
        end
        checkOutput("mid_update_memread", 32'(o_mem_read), 32'd0);
        checkOutput("mid_update_busy", 32'(o_busywait), 32'd1);
        checkOutput("mid_update_addr", 32'(o_mem_address), 32'h01);
        stepCycle();
        #1;
        checkOutput("second_miss_busy", 32'(o_busywait), 32'd1);
        waitReady("second_miss", 6'h02);
        checkOutput("blk2_word0", o_instruction, 32'h31201302);
        applyStimulus(32'h010);
        checkOutput("blk1_busy", 32'(o_busywait), 32'd0);
        checkOutput("blk1_word0", o_instruction, 32'h32231001);

        // Asynchronous reset in the middle of a refill.
        applyStimulus(32'h030);
        stepCycle();
        #1;
        checkOutput("prerst_memread", 32'(o_mem_read), 32'd1);
        checkOutput("prerst_addr", 32'(o_mem_address), 32'h03);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_memread", 32'(o_mem_read), 32'd0);
        checkOutput("midrst_busy", 32'(o_busywait), 32'd0);
        checkOutput("midrst_instr", o_instruction, 32'd0);
        checkOutput("midrst_addr", 32'(o_mem_address), 32'd0);
`ifdef ICACHE_STATS_EN
        checkOutput("midrst_hits", 32'(o_hit_count), 32'd0);
        checkOutput("midrst_misses", 32'(o_miss_count), 32'd0);
`endif
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        i_pc = 32'h000;
        #1;
        checkOutput("postrst_busy", 32'(o_busywait), 32'd1);
        waitReady("postrst", 6'h00);
        checkOutput("postrst_word0", o_instruction, 32'h33221100);

        // Bit 10 and above are ignored, so 0x404 aliases 0x004.
        applyStimulus(32'h404);
        checkOutput("alias_busy", 32'(o_busywait), 32'd0);
        checkOutput("alias_word1", o_instruction, 32'h77665544);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
